// File: rtl/hi_iso14443a_miller_tx_if.sv
// hi_iso14443a_miller_tx_if: byte handshake between the ARM-side byte path and the Miller transmitter
// Signals:
//   tx_data   - frame byte, sent LSB first
//   tx_valid  - tx_data/tx_last/tx_bits/parity_en are valid
//   tx_ready  - transmitter holding register is empty
//   tx_last   - byte is the final byte of the frame
//   tx_bits   - valid bits in the final byte (0 means 8)
//   parity_en - append odd parity after a full 8-bit byte
// Modports: master drives the byte, slave is the transmitter.
interface hi_iso14443a_miller_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;
    logic [2:0] tx_bits;
    logic       parity_en;

    modport master (output tx_data, tx_valid, tx_last, tx_bits, parity_en, input tx_ready);
    modport slave  (input tx_data, tx_valid, tx_last, tx_bits, parity_en, output tx_ready);
endinterface

// File: rtl/hi_iso14443a_miller_tx.sv
// hi_iso14443a_miller_tx: ISO14443-A reader-to-tag Modified Miller transmitter (106 kbit/s)
// Ports:
//   ck_1356meg - 13.56 MHz carrier clock; all logic runs on its falling edge
//   nreset     - asynchronous active-low reset
//   tx         - byte handshake, slave side (data, valid, ready, last, bits, parity_en)
//   mod_pause  - registered carrier pause, 1 = carrier dropped
//   busy       - frame in progress, from SOC through the end of EOC
//   underrun   - one-clock pulse when no byte is waiting at a byte boundary of an unfinished frame
module hi_iso14443a_miller_tx #(
    parameter int BIT_LEN   = 128,
    parameter int PAUSE_LEN = 32
) (
    input  logic                    ck_1356meg,
    input  logic                    nreset,
    hi_iso14443a_miller_tx_if.slave tx,
    output logic                    mod_pause,
    output logic                    busy,
    output logic                    underrun
);
    localparam int TW = $clog2(BIT_LEN);

    typedef enum logic [2:0] {IDLE, SOC, DATA, PAR, EOC0, EOC1} state_t;
    typedef enum logic [1:0] {SYM_Y, SYM_X, SYM_Z} sym_t;

    state_t        state, state_n;
    sym_t          sym, sym_n;
    logic [TW-1:0] timer, timer_n;
    logic          prev_bit, prev_n;
    logic [7:0]    sh, sh_n;
    logic [2:0]    cnt, cnt_n, cnt_end, cnt_end_n;
    logic          par_bit, par_bit_n;
    logic          par_go, par_go_n;
    logic          last, last_n;

    logic [7:0]    hold_data;
    logic [2:0]    hold_bits;
    logic          hold_last, hold_par_en, hold_full, hold_full_n, hold_wr;

    logic [7:0]    src_data;
    logic [2:0]    src_bits;
    logic          src_last, src_par_en, src_short;
    logic          accept, load, byte_end, period_end, pause_n, underrun_n;

    // Logic 1 -> X; logic 0 -> Y after a 1, Z after a 0 or SOC.
    function automatic sym_t enc(input logic b, input logic p);
        return b ? SYM_X : (p ? SYM_Y : SYM_Z);
    endfunction

    assign tx.tx_ready = ~hold_full;
    assign busy        = (state != IDLE);
    assign accept      = tx.tx_valid && !hold_full;
    // In IDLE an accepted byte bypasses the holding register straight into the shifter.
    assign hold_wr     = accept && (state != IDLE);
    assign period_end  = (int'(timer) == BIT_LEN - 1);

    // Any load takes the holding register if it is full, otherwise the bypass path.
    assign src_data    = hold_full ? hold_data   : tx.tx_data;
    assign src_bits    = hold_full ? hold_bits   : tx.tx_bits;
    assign src_last    = hold_full ? hold_last   : tx.tx_last;
    assign src_par_en  = hold_full ? hold_par_en : tx.parity_en;
    assign src_short   = src_last && (src_bits != 3'd0);

    always_comb begin
        state_n    = state;
        sym_n      = sym;
        timer_n    = (state == IDLE || period_end) ? '0 : timer + TW'(1);
        prev_n     = prev_bit;
        sh_n       = sh;
        cnt_n      = cnt;
        cnt_end_n  = cnt_end;
        par_bit_n  = par_bit;
        par_go_n   = par_go;
        last_n     = last;
        load       = 1'b0;
        byte_end   = 1'b0;
        underrun_n = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full || tx.tx_valid) begin
                    state_n = SOC;
                    sym_n   = SYM_Z;
                    prev_n  = 1'b0;
                    load    = 1'b1;
                end
            end
            SOC: begin
                if (period_end) begin
                    state_n = DATA;
                    sym_n   = enc(sh[0], prev_bit);
                    prev_n  = sh[0];
                end
            end
            DATA: begin
                if (period_end) begin
                    if (cnt != cnt_end) begin
                        cnt_n  = cnt + 3'd1;
                        sh_n   = sh >> 1;
                        sym_n  = enc(sh[1], prev_bit);
                        prev_n = sh[1];
                    end else if (par_go) begin
                        state_n = PAR;
                        sym_n   = enc(par_bit, prev_bit);
                        prev_n  = par_bit;
                    end else begin
                        byte_end = 1'b1;
                    end
                end
            end
            PAR: begin
                if (period_end) byte_end = 1'b1;
            end
            EOC0: begin
                if (period_end) begin
                    state_n = EOC1;
                    sym_n   = SYM_Y;
                end
            end
            EOC1: begin
                if (period_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (byte_end) begin
            if (last || !hold_full) begin
                state_n    = EOC0;
                sym_n      = enc(1'b0, prev_bit);
                underrun_n = !last;
            end else begin
                state_n = DATA;
                load    = 1'b1;
                sym_n   = enc(hold_data[0], prev_bit);
                prev_n  = hold_data[0];
            end
        end
        if (load) begin
            sh_n      = src_data;
            cnt_n     = 3'd0;
            cnt_end_n = src_short ? src_bits - 3'd1 : 3'd7;
            par_bit_n = ~^src_data;
            par_go_n  = src_par_en && !src_short;
            last_n    = src_last;
        end
        // Pause is registered, so it trails the timer by one clock but keeps exact widths.
        pause_n = (state != IDLE) &&
                  ((sym == SYM_Z && int'(timer) < PAUSE_LEN) ||
                   (sym == SYM_X && int'(timer) >= BIT_LEN / 2 && int'(timer) < BIT_LEN / 2 + PAUSE_LEN));
    end

    assign hold_full_n = hold_wr || (hold_full && !load);

    always_ff @(negedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            sym         <= SYM_Y;
            timer       <= '0;
            prev_bit    <= 1'b0;
            sh          <= '0;
            cnt         <= '0;
            cnt_end     <= '0;
            par_bit     <= 1'b0;
            par_go      <= 1'b0;
            last        <= 1'b0;
            hold_data   <= '0;
            hold_bits   <= '0;
            hold_last   <= 1'b0;
            hold_par_en <= 1'b0;
            hold_full   <= 1'b0;
            mod_pause   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_n;
            sym         <= sym_n;
            timer       <= timer_n;
            prev_bit    <= prev_n;
            sh          <= sh_n;
            cnt         <= cnt_n;
            cnt_end     <= cnt_end_n;
            par_bit     <= par_bit_n;
            par_go      <= par_go_n;
            last        <= last_n;
            hold_full   <= hold_full_n;
            mod_pause   <= pause_n;
            underrun    <= underrun_n;
            if (hold_wr) begin
                hold_data   <= tx.tx_data;
                hold_bits   <= tx.tx_bits;
                hold_last   <= tx.tx_last;
                hold_par_en <= tx.parity_en;
            end
        end
    end
endmodule

// File: tb/tb_hi_iso14443a_miller_tx.sv
// tb_hi_iso14443a_miller_tx: directed, table-driven bench for the Modified Miller transmitter
module tb_hi_iso14443a_miller_tx;
    logic clk = 1'b0;
    logic nreset;
    logic en_b;
    logic mod_pause_a, busy_a, underrun_a;
    logic mod_pause_b, busy_b, underrun_b;

    always #5 clk = ~clk;

    hi_iso14443a_miller_tx_if ia();
    hi_iso14443a_miller_tx_if ib();

    assign ib.tx_data   = ia.tx_data;
    assign ib.tx_last   = ia.tx_last;
    assign ib.tx_bits   = ia.tx_bits;
    assign ib.parity_en = ia.parity_en;
    assign ib.tx_valid  = ia.tx_valid & en_b;

    hi_iso14443a_miller_tx dut_a (
        .ck_1356meg(clk), .nreset(nreset), .tx(ia),
        .mod_pause(mod_pause_a), .busy(busy_a), .underrun(underrun_a)
    );

    hi_iso14443a_miller_tx #(.BIT_LEN(64), .PAUSE_LEN(16)) dut_b (
        .ck_1356meg(clk), .nreset(nreset), .tx(ib),
        .mod_pause(mod_pause_b), .busy(busy_b), .underrun(underrun_b)
    );

    int checks = 0;
    int errors = 0;

    // Per-frame capture, sampled on the rising edge (DUT acts on the falling edge).
    bit trace_a[$], rdy_a[$], done_a[$], rdone_a[$];
    bit trace_b[$], done_b[$];
    int frames_a = 0, frames_b = 0, ur_a = 0, idle_run = 0, last_gap = -1;

    initial begin
        bit bq;
        bq = 1'b0;
        forever begin
            @(posedge clk);
            if (busy_a) begin
                if (!bq) last_gap = idle_run;
                idle_run = 0;
                trace_a.push_back(mod_pause_a);
                rdy_a.push_back(ia.tx_ready);
            end else begin
                idle_run++;
                if (bq) begin
                    done_a = trace_a;
                    rdone_a = rdy_a;
                    trace_a.delete();
                    rdy_a.delete();
                    frames_a++;
                end
            end
            if (underrun_a) ur_a++;
            bq = busy_a;
        end
    end

    initial begin
        bit bq;
        bq = 1'b0;
        forever begin
            @(posedge clk);
            if (busy_b) trace_b.push_back(mod_pause_b);
            else if (bq) begin
                done_b = trace_b;
                trace_b.delete();
                frames_b++;
            end
            bq = busy_b;
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Expected waveform derived from a symbol string: Z pauses timer 0..P-1, X pauses L/2..L/2+P-1,
    // seen one sample later because the pause output is registered.
    task automatic check_wave(input string nm, input logic [255:0] syms, input int L, input int P, input bit q[$]);
        int n, bad, first, p, off;
        logic [7:0] c;
        bit e;
        n = 0; bad = 0; first = -1;
        for (int k = 0; k < 32; k++) if (syms[8*k +: 8] != 8'd0) n++;
        check({nm, " busy_len"}, q.size(), n * L);
        for (int i = 0; i < q.size(); i++) begin
            p = i / L;
            off = i % L;
            c = (p < n) ? syms[8*(n-1-p) +: 8] : 8'h59;
            e = (c == 8'h5A && off >= 1 && off <= P) || (c == 8'h58 && off >= L/2 + 1 && off <= L/2 + P);
            if (q[i] != e) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check($sformatf("%s wave (first bad sample %0d)", nm, first), bad, 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input logic [2:0] b, input logic p);
        int n;
        n = 0;
        ia.tx_data = d; ia.tx_last = l; ia.tx_bits = b; ia.parity_en = p; ia.tx_valid = 1'b1;
        while (!ia.tx_ready && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("send accepted", int'(ia.tx_ready), 1);
        @(posedge clk);
        ia.tx_valid = 1'b0;
    endtask

    task automatic wait_a(input int f0, input string nm);
        int n;
        n = 0;
        while (frames_a == f0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check({nm, " frame done"}, int'(frames_a != f0), 1);
    endtask

    typedef struct {
        logic [7:0]   data;
        logic         last;
        logic [2:0]   bits;
        logic         par;
        logic [255:0] syms;
        int           urs;
    } vec_t;

    vec_t vt[6];

    initial begin
        int f0, u0, n;
        nreset = 1'b0; en_b = 1'b0;
        ia.tx_valid = 1'b0; ia.tx_data = '0; ia.tx_last = 1'b0; ia.tx_bits = '0; ia.parity_en = 1'b0;
        vt[0] = '{8'h26, 1'b1, 3'd7, 1'b1, 256'("ZZXXYZXYZY"),   0};
        vt[1] = '{8'h01, 1'b1, 3'd0, 1'b1, 256'("ZXYZZZZZZZZY"), 0};
        vt[2] = '{8'hFF, 1'b0, 3'd0, 1'b1, 256'("ZXXXXXXXXXYY"), 1};
        vt[3] = '{8'hFF, 1'b1, 3'd0, 1'b0, 256'("ZXXXXXXXXYY"),  0};
        vt[4] = '{8'h00, 1'b1, 3'd3, 1'b1, 256'("ZZZZZY"),       0};
        vt[5] = '{8'hA5, 1'b1, 3'd0, 1'b1, 256'("ZXYXYZXYXXYY"), 0};

        repeat (3) @(posedge clk);
        nreset = 1'b1;
        @(posedge clk);
        check("reset mod_pause", int'(mod_pause_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset underrun", int'(underrun_a), 0);
        check("reset tx_ready", int'(ia.tx_ready), 1);

        for (int v = 0; v < 6; v++) begin
            f0 = frames_a;
            u0 = ur_a;
            send_byte(vt[v].data, vt[v].last, vt[v].bits, vt[v].par);
            wait_a(f0, $sformatf("vec%0d", v));
            check_wave($sformatf("vec%0d", v), vt[v].syms, 128, 32, done_a);
            check($sformatf("vec%0d underruns", v), ur_a - u0, vt[v].urs);
            repeat (5) @(posedge clk);
        end

        // Two bytes, second queued in the holding register while the first shifts.
        f0 = frames_a;
        send_byte(8'h93, 1'b0, 3'd0, 1'b1);
        send_byte(8'h20, 1'b1, 3'd0, 1'b1);
        check("two_byte ready while held", int'(ia.tx_ready), 0);
        wait_a(f0, "two_byte");
        check_wave("two_byte", 256'("ZXXYZXYZXXYZZZZXYZZZY"), 128, 32, done_a);
        check("two_byte ready before drain", int'(rdone_a[10*128-1]), 0);
        check("two_byte ready after drain", int'(rdone_a[10*128]), 1);
        repeat (5) @(posedge clk);

        // Next frame's byte offered during EOC1.
        f0 = frames_a;
        send_byte(8'h00, 1'b1, 3'd3, 1'b1);
        n = 0;
        while (trace_a.size() < 5*128 + 10 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        send_byte(8'h01, 1'b1, 3'd1, 1'b1);
        wait_a(f0, "b2b first");
        check_wave("b2b first", 256'("ZZZZZY"), 128, 32, done_a);
        wait_a(f0 + 1, "b2b second");
        check("b2b idle gap", last_gap, 1);
        check_wave("b2b second", 256'("ZXYY"), 128, 32, done_a);
        repeat (5) @(posedge clk);

        // Reset during the X pause of the second bit.
        send_byte(8'h03, 1'b1, 3'd0, 1'b1);
        n = 0;
        while (trace_a.size() < 2*128 + 74 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("rst pause active before reset", int'(mod_pause_a), 1);
        #1 nreset = 1'b0;
        #1;
        check("rst async mod_pause", int'(mod_pause_a), 0);
        check("rst async busy", int'(busy_a), 0);
        check("rst async tx_ready", int'(ia.tx_ready), 1);
        @(posedge clk);
        nreset = 1'b1;
        repeat (3) @(posedge clk);
        f0 = frames_a;
        send_byte(vt[0].data, vt[0].last, vt[0].bits, vt[0].par);
        wait_a(f0, "after reset");
        check_wave("after reset", vt[0].syms, 128, 32, done_a);
        repeat (5) @(posedge clk);

        // Short bit period instance.
        en_b = 1'b1;
        f0 = frames_b;
        send_byte(8'h01, 1'b1, 3'd0, 1'b1);
        en_b = 1'b0;
        n = 0;
        while (frames_b == f0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("sweep64 frame done", int'(frames_b != f0), 1);
        check_wave("sweep64", 256'("ZXYZZZZZZZZY"), 64, 16, done_b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
